// File: rtl/irq_pending_arbiter_pkg.sv
// Shared types and constants for the pending-request arbiter and its priority picker.
package irq_pkg;
  localparam int IRQ_N_REQ = 8;
  localparam int IRQ_IDX_W = 3;

  typedef logic [IRQ_N_REQ-1:0] irq_vec_t;
  typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

  typedef enum logic {IDLE, OFFER} irq_arb_state_e;

  // Lines whose index has bit b set; ORing one-hot winners through it yields index bit b.
  function automatic irq_vec_t idx_bit_mask(input int b);
    irq_vec_t m;
    m = '0;
    for (int i = 0; i < IRQ_N_REQ; i++) begin
      m[i] = i[b];
    end
    return m;
  endfunction
endpackage

// File: rtl/irq_pending_arbiter_prio_pick.sv
// Combinational 8-in priority picker: highest set index wins, plus an any flag.
module irq_prio_pick
  import irq_pkg::*;
(
  input  logic [IRQ_N_REQ-1:0] req,
  output logic [IRQ_IDX_W-1:0] idx,
  output logic                 any
);
  irq_vec_t win;

  genvar gi;
  generate
    for (gi = 0; gi < IRQ_N_REQ; gi++) begin : g_win
      if (gi == IRQ_N_REQ - 1) begin : g_top
        assign win[gi] = req[gi];
      end else begin : g_low
        assign win[gi] = req[gi] & ~(|req[IRQ_N_REQ-1:gi+1]);
      end
    end

    for (gi = 0; gi < IRQ_IDX_W; gi++) begin : g_idx
      assign idx[gi] = |(win & idx_bit_mask(gi));
    end
  endgenerate

  assign any = |req;
endmodule

// File: rtl/irq_pending_arbiter.sv
// Rising-edge request capture, pending hold and valid/ready offer of the highest unmasked index.
// Optional sticky lost-edge flags are built when IRQ_OVERRUN_DETECT_EN is defined.
module irq_pending_arbiter
  import irq_pkg::*;
#(
  parameter int N_REQ = IRQ_N_REQ,
  parameter int IDX_W = IRQ_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask_in,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ready,
  output logic [N_REQ-1:0] pending_o
`ifdef IRQ_OVERRUN_DETECT_EN
  ,
  output logic [N_REQ-1:0] overrun_o
`endif
);
  generate
    if (N_REQ != IRQ_N_REQ || IDX_W != IRQ_IDX_W) begin : g_bad_param
      $error("irq_pending_arbiter supports only N_REQ=8 and IDX_W=3");
    end
  endgenerate

  irq_vec_t       req_reg;
  irq_vec_t       pending_reg;
  irq_vec_t       pending_next;
  irq_vec_t       rise;
  irq_vec_t       clr;
  irq_vec_t       cand;
  irq_idx_t       idx_reg;
  irq_idx_t       idx_next;
  irq_idx_t       pick_idx;
  logic           pick_any;
  logic           accept;
  irq_arb_state_e state_reg;
  irq_arb_state_e state_next;

  assign accept       = (state_reg == OFFER) && irq_ready;
  assign rise         = req_in & ~req_reg;
  assign clr          = accept ? (irq_vec_t'(1) << idx_reg) : '0;
  assign pending_next = (pending_reg & ~clr) | rise;
  // The line being accepted this cycle must not be re-picked from stale pending state.
  assign cand         = pending_reg & mask_in & ~clr;

  irq_prio_pick u_pick (
    .req (cand),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          idx_next   = pick_idx;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (irq_ready) begin
          if (pick_any) begin
            idx_next = pick_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Capture the live level so a line held high through reset needs a fresh rise.
      req_reg     <= req_in;
      pending_reg <= '0;
      idx_reg     <= '0;
      state_reg   <= IDLE;
    end else begin
      req_reg     <= req_in;
      pending_reg <= pending_next;
      idx_reg     <= idx_next;
      state_reg   <= state_next;
    end
  end

`ifdef IRQ_OVERRUN_DETECT_EN
  irq_vec_t overrun_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_reg <= '0;
    end else begin
      overrun_reg <= overrun_reg | (rise & pending_reg & ~clr);
    end
  end

  assign overrun_o = overrun_reg;
`endif

  assign irq_valid = (state_reg == OFFER);
  assign irq_idx   = idx_reg;
  assign pending_o = pending_reg;
endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed plus randomized bench for irq_pending_arbiter against a per-line behavioural model.
module tb_irq_pending_arbiter;
  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask_in;
  logic       irq_valid;
  logic [2:0] irq_idx;
  logic       irq_ready;
  logic [7:0] pending_o;
`ifdef IRQ_OVERRUN_DETECT_EN
  logic [7:0] overrun_o;
`endif

  int compared;
  int mismatched;

  // Reference model state
  logic [7:0] m_pend;
  logic [7:0] m_prev;
  logic [7:0] m_ovr;
  bit         m_valid;
  int         m_idx;

  irq_pending_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask_in   (mask_in),
    .irq_valid (irq_valid),
    .irq_idx   (irq_idx),
    .irq_ready (irq_ready),
    .pending_o (pending_o)
`ifdef IRQ_OVERRUN_DETECT_EN
    ,
    .overrun_o (overrun_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the spec: accept clears, offered line is excluded, rises set, offer holds until taken.
  task automatic model_edge(input logic [7:0] r, input logic [7:0] m, input logic rd, input logic rs);
    bit         acc;
    int         best;
    logic [7:0] old;
    if (rs) begin
      m_pend  = '0;
      m_ovr   = '0;
      m_prev  = r;
      m_valid = 0;
      m_idx   = 0;
      return;
    end
    acc  = m_valid && rd;
    old  = m_pend;
    best = -1;
    for (int i = 0; i < 8; i++) begin
      if (old[i] && m[i] && !(acc && i == m_idx)) best = i;
    end
    for (int i = 0; i < 8; i++) begin
      if (acc && i == m_idx) m_pend[i] = 1'b0;
      if (r[i] && !m_prev[i]) begin
        if (old[i] && !(acc && i == m_idx)) m_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    m_prev = r;
    if (!m_valid || acc) begin
      if (best >= 0) begin
        m_valid = 1;
        m_idx   = best;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("valid", {7'b0, irq_valid}, {7'b0, m_valid});
    if (m_valid) chk("idx", {5'b0, irq_idx}, 8'(m_idx));
    chk("pending", pending_o, m_pend);
`ifdef IRQ_OVERRUN_DETECT_EN
    chk("overrun", overrun_o, m_ovr);
`endif
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] m, input logic rd, input logic rs);
    req_in    = r;
    mask_in   = m;
    irq_ready = rd;
    rst       = rs;
    @(posedge clk);
    model_edge(r, m, rd, rs);
    #1;
    check_model();
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] mk;
    compared   = 0;
    mismatched = 0;
    m_pend = '0; m_prev = '0; m_ovr = '0; m_valid = 0; m_idx = 0;
    req_in = '0; mask_in = 8'hFF; irq_ready = 0; rst = 1;

    // Reset state
    step(8'h00, 8'hFF, 0, 1);
    step(8'h00, 8'hFF, 0, 1);
    chk("rst_valid", {7'b0, irq_valid}, 8'h00);
    chk("rst_idx", {5'b0, irq_idx}, 8'h00);
    chk("rst_pending", pending_o, 8'h00);

    // Single pulse on bit 2: offered two edges later, held, then accepted
    step(8'h04, 8'hFF, 0, 0);
    chk("p2_pend", pending_o, 8'h04);
    chk("p2_nooffer", {7'b0, irq_valid}, 8'h00);
    step(8'h00, 8'hFF, 0, 0);
    chk("p2_valid", {7'b0, irq_valid}, 8'h01);
    chk("p2_idx", {5'b0, irq_idx}, 8'h02);
    step(8'h00, 8'hFF, 0, 0);
    chk("p2_hold", {5'b0, irq_idx}, 8'h02);
    step(8'h00, 8'hFF, 1, 0);
    chk("p2_cleared", pending_o, 8'h00);
    chk("p2_idle", {7'b0, irq_valid}, 8'h00);

    // Bits 7 and 0 together, ready held: back-to-back grants
    step(8'h81, 8'hFF, 1, 0);
    step(8'h00, 8'hFF, 1, 0);
    chk("b2b_idx7", {5'b0, irq_idx}, 8'h07);
    step(8'h00, 8'hFF, 1, 0);
    chk("b2b_valid0", {7'b0, irq_valid}, 8'h01);
    chk("b2b_idx0", {5'b0, irq_idx}, 8'h00);
    step(8'h00, 8'hFF, 1, 0);
    chk("b2b_done", pending_o, 8'h00);

    // Higher-priority arrival waits behind the current offer
    step(8'h04, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 0);
    step(8'h40, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 0);
    chk("stable_idx", {5'b0, irq_idx}, 8'h02);
    chk("stable_pend", pending_o, 8'h44);
    step(8'h00, 8'hFF, 1, 0);
    chk("next_idx6", {5'b0, irq_idx}, 8'h06);
    step(8'h00, 8'hFF, 1, 0);

    // Masked pending bit becomes eligible once unmasked
    step(8'h08, 8'hF7, 0, 0);
    step(8'h00, 8'hF7, 0, 0);
    chk("mask_nooffer", {7'b0, irq_valid}, 8'h00);
    chk("mask_pend", pending_o, 8'h08);
    step(8'h00, 8'hFF, 0, 0);
    chk("unmask_idx3", {5'b0, irq_idx}, 8'h03);
    step(8'h00, 8'hFF, 1, 0);

    // Rise on the line being accepted: set wins, line is offered again
    step(8'h20, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 0);
    step(8'h20, 8'hFF, 1, 0);
    chk("setwins_pend", pending_o, 8'h20);
    step(8'h00, 8'hFF, 0, 0);
    chk("reoffer_idx5", {5'b0, irq_idx}, 8'h05);
    step(8'h00, 8'hFF, 1, 0);

    // Second rise on a pending, unaccepted line
    step(8'h02, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 0, 0);
    step(8'h02, 8'hFF, 0, 0);
`ifdef IRQ_OVERRUN_DETECT_EN
    chk("overrun_bit1", overrun_o, 8'h02);
`endif
    chk("merged_pend", pending_o, 8'h02);
    step(8'h00, 8'hFF, 1, 0);

    // Reset during an offer with everything pending; held lines stay silent
    step(8'hFF, 8'hFF, 0, 0);
    step(8'hFF, 8'hFF, 0, 0);
    chk("pre_rst_pend", pending_o, 8'hFF);
    step(8'hFF, 8'hFF, 0, 1);
    chk("rst_drop_valid", {7'b0, irq_valid}, 8'h00);
    chk("rst_drop_pend", pending_o, 8'h00);
    step(8'hFF, 8'hFF, 0, 0);
    step(8'hFF, 8'hFF, 0, 0);
    chk("held_no_offer", {7'b0, irq_valid}, 8'h00);
    step(8'h00, 8'hFF, 0, 0);
    step(8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 1, 0);
    chk("refire_idx7", {5'b0, irq_idx}, 8'h07);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r  = 8'($urandom);
      mk = 8'($urandom | $urandom);
      step(r, mk, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
